iram_access_sequencer: RTL
==========================

Name: iram_access_sequencer

Overview:
Owns the single instruction-RAM port and time-shares it between an external program loader and core instruction fetch. Sequences bring-up: streams a program into iram over a valid/ready handshake, then releases the core by driving core_start and muxing pc onto the iram address. Sits between the board-level loader interface, the core and iram, replacing the ad-hoc start/start_2 muxing in the top level.

Parameters:
ADDR_W, 9, iram address width
DATA_W, 16, instruction word width
DEPTH, 512, iram words; must satisfy DEPTH <= 2**ADDR_W

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
load_req  in  1  request to enter LOAD; ld_base sampled on the same edge
ld_base  in  ADDR_W  first iram address for the load
ld_valid  in  1  loader word valid
ld_ready  out  1  sequencer accepts word
ld_data  in  DATA_W  loader word
ld_last  in  1  marks final word of the load, qualified by ld_valid
run_req  in  1  release the core
halt_req  in  1  stop the core and return to IDLE
pc_in  in  16  core program counter
core_read_en  in  1  core fetch enable
core_start  out  1  level; core runs while high
iram_addr  out  ADDR_W  registered iram address
iram_write  out  1  registered iram write strobe
iram_read  out  1  registered iram read strobe
iram_wdata  out  DATA_W  registered iram write data
state  out  2  IDLE=0, LOAD=1, RUN=2, DRAIN=3
load_count  out  ADDR_W+1  words written in current/last load
overflow_err  out  1  sticky load-overflow flag

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, ld_ready=0, core_start=0, iram_addr=0, iram_write=0, iram_read=0, iram_wdata=0, load_count=0, overflow_err=0. Reset mid-LOAD cancels any pending write; no write appears the following cycle.
- IDLE: load_req=1 -> LOAD; ptr<=ld_base, load_count<=0, overflow_err<=0. Else run_req=1 -> RUN. load_req has priority over run_req. halt_req ignored.
- LOAD: ld_ready=1 combinationally while state==LOAD. A beat is accepted when ld_valid&ld_ready. Accepted beat at edge n -> at n+1: iram_write=1, iram_addr=ptr, iram_wdata=ld_data; ptr increments, load_count increments. One-cycle write latency; back-to-back beats give consecutive writes every cycle.
- LOAD exit: accepted beat with ld_last=1 -> IDLE after that write. Accepted beat with ptr==DEPTH-1 and ld_last=0 -> write performed, overflow_err<=1, -> IDLE. ptr never wraps past DEPTH-1.
- load_req, run_req, halt_req ignored in LOAD.
- RUN: core_start=1 from the first cycle in RUN. iram_addr<=pc_in[ADDR_W-1:0] each cycle, iram_read<=core_read_en, iram_write=0 always. pc_in upper bits ignored. load_req ignored.
- RUN + halt_req=1 -> DRAIN; core_start<=0 on the same edge. DRAIN lasts exactly one cycle (lets the in-flight iram read complete, iram_read=0), then -> IDLE.
- Outside LOAD, iram_write=0. Outside RUN, iram_read=0 and core_start=0.
- load_count saturates at DEPTH; holds its value in IDLE/RUN until the next load_req.

Optional Feature:
IRAM_LOAD_CHECKSUM_EN: adds ports ld_csum_exp (in, DATA_W) and csum_err (out, 1, sticky). Running modulo-2**DATA_W sum of accepted ld_data, cleared at load_req. At the final beat (ld_last) sum including that word is compared to ld_csum_exp; mismatch sets csum_err. While csum_err=1, run_req is ignored in IDLE. Cleared by reset or load_req. Without the macro: no ports, no checks, run_req always honoured in IDLE.

Test Plan:
- Reset then load_req with ld_base=0x010, 4 back-to-back beats 0xA001..0xA004, last on 4th -> writes at 0x010..0x013 one cycle after each beat, load_count=4, state returns to 0.
- load_req, ld_valid toggled 1,0,1,0,1(last) -> exactly 3 writes, no write on gap cycles, addresses contiguous.
- ld_base=0x1FE, 3 beats no last -> writes at 0x1FE and 0x1FF only, overflow_err=1, state=IDLE, ld_ready=0.
- run_req, pc_in=0x0123, core_read_en=1 -> core_start=1, next cycle iram_addr=0x123, iram_read=1; halt_req -> core_start=0, one DRAIN cycle, IDLE.
- load_req and run_req asserted together in IDLE -> LOAD; rst_n=0 mid-load after an accepted beat -> iram_write=0 next cycle, all outputs at reset values.
- With IRAM_LOAD_CHECKSUM_EN: load 0x0001,0x0002 with ld_csum_exp=0x0004 -> csum_err=1, subsequent run_req keeps core_start=0.

Source files
------------

// File: rtl/iram_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// iram_access_sequencer_if
//   Program-loader handshake bundle between the board-level loader and the
//   instruction-RAM access sequencer.
//
//   Signals:
//     load_req    loader -> sequencer  request a new load (ld_base sampled too)
//     ld_base     loader -> sequencer  first iram address of the load
//     ld_valid    loader -> sequencer  ld_data/ld_last valid this cycle
//     ld_ready    sequencer -> loader  sequencer accepts a word this cycle
//     ld_data     loader -> sequencer  instruction word
//     ld_last     loader -> sequencer  final word of the load (with ld_valid)
//     ld_csum_exp loader -> sequencer  expected load checksum
//                                      (only with IRAM_LOAD_CHECKSUM_EN)
//
//   Modports: master = loader side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface iram_access_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              load_req;
    logic [ADDR_W-1:0] ld_base;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
`ifdef IRAM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] ld_csum_exp;
`endif

    modport master (
        output load_req,
        output ld_base,
        output ld_valid,
        input  ld_ready,
        output ld_data,
        output ld_last
`ifdef IRAM_LOAD_CHECKSUM_EN
        ,
        output ld_csum_exp
`endif
    );

    modport slave (
        input  load_req,
        input  ld_base,
        input  ld_valid,
        output ld_ready,
        input  ld_data,
        input  ld_last
`ifdef IRAM_LOAD_CHECKSUM_EN
        ,
        input  ld_csum_exp
`endif
    );
endinterface

// File: rtl/iram_access_sequencer.sv
// -----------------------------------------------------------------------------
// iram_access_sequencer
//   Owns the single instruction-RAM port and time-shares it between the
//   external program loader (LOAD) and core instruction fetch (RUN).
//   Bring-up: stream a program into iram, then release the core with
//   core_start and mux the core pc onto the iram address.
//
//   Optional feature macro: IRAM_LOAD_CHECKSUM_EN
//     Adds ld_csum_exp (in the loader interface) and the sticky csum_err
//     output. A mismatching load checksum blocks run_req in IDLE.
//
//   Ports:
//     clock         system clock, rising edge
//     rst_n         synchronous active-low reset
//     ld            loader handshake (slave modport)
//     run_req       release the core (IDLE only)
//     halt_req      stop the core (RUN only) -> DRAIN -> IDLE
//     pc_in         core program counter, low ADDR_W bits address iram
//     core_read_en  core fetch enable
//     core_start    core runs while high
//     iram_addr     registered iram address
//     iram_write    registered iram write strobe
//     iram_read     registered iram read strobe
//     iram_wdata    registered iram write data
//     state         IDLE=0, LOAD=1, RUN=2, DRAIN=3
//     load_count    words written in current/last load (saturates at DEPTH)
//     overflow_err  sticky: load ran into the top of iram without ld_last
//     csum_err      sticky checksum mismatch (IRAM_LOAD_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module iram_access_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512   // must satisfy DEPTH <= 2**ADDR_W
) (
    input  logic                  clock,
    input  logic                  rst_n,
    iram_access_sequencer_if.slave ld,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic [15:0]           pc_in,
    input  logic                  core_read_en,
    output logic                  core_start,
    output logic [ADDR_W-1:0]     iram_addr,
    output logic                  iram_write,
    output logic                  iram_read,
    output logic [DATA_W-1:0]     iram_wdata,
    output logic [1:0]            state,
    output logic [ADDR_W:0]       load_count,
    output logic                  overflow_err
`ifdef IRAM_LOAD_CHECKSUM_EN
    ,
    output logic                  csum_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            cur_state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;

    // pc_in is wider than the iram address; the upper bits are don't-care.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc_in[15:ADDR_W];

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
        return (c >= COUNT_MAX) ? COUNT_MAX : c + 1'b1;
    endfunction

    // ld_ready is a pure decode of the state register, so it drops on the
    // same edge that leaves LOAD and no beat beyond ld_last/overflow is taken.
    assign ld.ld_ready = (cur_state == S_LOAD);
    assign accept      = (cur_state == S_LOAD) && ld.ld_valid;
    assign state       = cur_state;

`ifdef IRAM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_sum;
    logic [DATA_W-1:0] csum_next;
    logic              run_allowed;
    assign csum_next   = csum_sum + ld.ld_data;
    assign run_allowed = !csum_err;
`else
    logic run_allowed;
    assign run_allowed = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cur_state    <= S_IDLE;
            ptr          <= '0;
            core_start   <= 1'b0;
            iram_addr    <= '0;
            iram_write   <= 1'b0;
            iram_read    <= 1'b0;
            iram_wdata   <= '0;
            load_count   <= '0;
            overflow_err <= 1'b0;
`ifdef IRAM_LOAD_CHECKSUM_EN
            csum_sum     <= '0;
            csum_err     <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle unless re-armed below.
            iram_write <= 1'b0;
            iram_read  <= 1'b0;

            case (cur_state)
                S_IDLE: begin
                    core_start <= 1'b0;
                    if (ld.load_req) begin
                        cur_state    <= S_LOAD;
                        ptr          <= ld.ld_base;
                        load_count   <= '0;
                        overflow_err <= 1'b0;
`ifdef IRAM_LOAD_CHECKSUM_EN
                        csum_sum     <= '0;
                        csum_err     <= 1'b0;
`endif
                    end else if (run_req && run_allowed) begin
                        cur_state  <= S_RUN;
                        core_start <= 1'b1;
                    end
                end

                S_LOAD: begin
                    core_start <= 1'b0;
                    if (accept) begin
                        // Write lands one cycle after acceptance; the state
                        // leaves LOAD on the same edge for the final beat.
                        iram_write <= 1'b1;
                        iram_addr  <= ptr;
                        iram_wdata <= ld.ld_data;
                        load_count <= sat_inc(load_count);
                        if (ptr != LAST_ADDR) begin
                            ptr <= ptr + 1'b1;
                        end
`ifdef IRAM_LOAD_CHECKSUM_EN
                        csum_sum <= csum_next;
                        if (ld.ld_last && (csum_next != ld.ld_csum_exp)) begin
                            csum_err <= 1'b1;
                        end
`endif
                        if (ld.ld_last) begin
                            cur_state <= S_IDLE;
                        end else if (ptr == LAST_ADDR) begin
                            overflow_err <= 1'b1;
                            cur_state    <= S_IDLE;
                        end
                    end
                end

                S_RUN: begin
                    if (halt_req) begin
                        // Address holds so the in-flight read finishes in DRAIN.
                        cur_state  <= S_DRAIN;
                        core_start <= 1'b0;
                    end else begin
                        core_start <= 1'b1;
                        iram_addr  <= pc_in[ADDR_W-1:0];
                        iram_read  <= core_read_en;
                    end
                end

                S_DRAIN: begin
                    core_start <= 1'b0;
                    cur_state  <= S_IDLE;
                end

                default: begin
                    core_start <= 1'b0;
                    cur_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
